// File: rtl/fnd_stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its button/display neighbours.
// UPD is a bare strobe: there is no ready, and the consumer must take BCD_OUT in the cycle UPD is high.
interface fnd_stopwatch_ctrl_if;
  logic        BTN_START;
  logic        BTN_CLEAR;
  logic        BTN_LAP;
  logic [15:0] BCD_OUT;
  logic        RUNNING;
  logic        LAP_ACTIVE;
  logic        UPD;
  logic [1:0]  dbg_state;

  modport master (
    output BTN_START, BTN_CLEAR, BTN_LAP,
    input  BCD_OUT, RUNNING, LAP_ACTIVE, UPD, dbg_state
  );

  modport slave (
    input  BTN_START, BTN_CLEAR, BTN_LAP,
    output BCD_OUT, RUNNING, LAP_ACTIVE, UPD, dbg_state
  );
endinterface

// File: rtl/fnd_stopwatch_ctrl.sv
// Stopwatch time source: debounced buttons, IDLE/RUN/PAUSE control, SS.CC BCD time with lap freeze.
// BCD_OUT is registered and UPD marks each cycle in which it takes a new value.
module fnd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 240000,
  parameter int unsigned DEB_CYCLES = 240000
) (
  input logic                  CLK,
  input logic                  RESET,
  fnd_stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Button lanes: [0]=start, [1]=clear, [2]=lap.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    acc, acc_d;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   time_q, time_inc;
  logic [15:0]   lap_reg;
  logic          lap_active, lap_active_nxt;
  logic          lap_capture;
  logic          clear_time;
  logic [15:0]   disp_nxt;
  logic [15:0]   bcd_out;
  logic          upd;

  assign btn_raw = {bus.BTN_LAP, bus.BTN_CLEAR, bus.BTN_START};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_d <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      acc_d <= acc;
      press <= acc & ~acc_d;
      // The accepted level only moves after DEB_CYCLES unbroken cycles of disagreement.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != acc[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            acc[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    lap_active_nxt = lap_active;
    lap_capture    = 1'b0;
    clear_time     = 1'b0;
    case (state)
      IDLE: begin
        if (press[0]) state_nxt = RUN;
      end
      RUN: begin
        if (press[0]) begin
          state_nxt      = PAUSE;
          lap_active_nxt = 1'b0;
        end else if (press[2]) begin
          if (lap_active) begin
            lap_active_nxt = 1'b0;
          end else begin
            lap_active_nxt = 1'b1;
            lap_capture    = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (press[0]) begin
          state_nxt = RUN;
        end else if (press[1]) begin
          state_nxt  = IDLE;
          clear_time = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tick = (state == RUN) && (presc == PRESC_MAX);

  // Digit-wise BCD increment with the seconds-tens digit wrapping 5 -> 0.
  always_comb begin
    time_inc = time_q;
    if (time_q[3:0] != 4'd9) begin
      time_inc[3:0] = time_q[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_q[7:4] != 4'd9) begin
        time_inc[7:4] = time_q[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_q[11:8] != 4'd9) begin
          time_inc[11:8] = time_q[11:8] + 4'd1;
        end else begin
          time_inc[11:8]  = 4'd0;
          time_inc[15:12] = (time_q[15:12] == 4'd5) ? 4'd0 : time_q[15:12] + 4'd1;
        end
      end
    end
  end

  assign disp_nxt = lap_active ? lap_reg : time_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc      <= '0;
      time_q     <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      bcd_out    <= '0;
      upd        <= 1'b0;
    end else begin
      lap_active <= lap_active_nxt;
      // Non-blocking capture takes the pre-increment time when a tick lands in the same cycle.
      if (lap_capture) lap_reg <= time_q;
      if (clear_time) begin
        presc  <= '0;
        time_q <= '0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) time_q <= time_inc;
      end
      bcd_out <= disp_nxt;
      upd     <= (disp_nxt != bcd_out);
    end
  end

  assign bus.BCD_OUT    = bcd_out;
  assign bus.RUNNING    = (state == RUN);
  assign bus.LAP_ACTIVE = lap_active;
  assign bus.UPD        = upd;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_fnd_stopwatch_ctrl.sv
// Directed bench for fnd_stopwatch_ctrl: a time model pushes every expected display value,
// and a negedge monitor pops one per UPD pulse.
module tb_fnd_stopwatch_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fnd_stopwatch_ctrl_if bus();

  fnd_stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // Model, running 7 cycles ahead of the DUT (the fixed button-to-effect latency);
  // m_state: 0 idle, 1 run, 2 pause.
  int          m_state;
  int          m_phase;
  logic [15:0] m_time;
  logic [15:0] m_lap;
  bit          m_lap_on;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    int cs, sec, cc;
    cs  = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    cs  = (cs + 1) % 6000;
    sec = cs / 100;
    cc  = cs % 100;
    return {4'(sec / 10), 4'(sec % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_phase  = 0;
    m_time   = 16'h0000;
    m_lap    = 16'h0000;
    m_lap_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    if (m_state == 1) begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_time  = bcd_inc(m_time);
        if (!m_lap_on) exp_q.push_back(m_time);
      end
    end
  endtask

  task automatic model_unlap();
    m_lap_on = 1'b0;
    if (m_lap != m_time) exp_q.push_back(m_time);
  endtask

  task automatic model_press(input bit s, input bit c, input bit l);
    case (m_state)
      0: if (s) m_state = 1;
      1: begin
        if (s) begin
          m_state = 2;
          if (m_lap_on) model_unlap();
        end else if (l) begin
          if (m_lap_on) begin
            model_unlap();
          end else begin
            m_lap    = m_time;
            m_lap_on = 1'b1;
          end
        end
      end
      2: begin
        if (s) begin
          m_state = 1;
        end else if (c) begin
          if (m_time != 16'h0000) exp_q.push_back(16'h0000);
          m_time  = 16'h0000;
          m_phase = 0;
          m_state = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // Driver tasks
  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic press(input bit s, input bit c, input bit l);
    @(negedge clk);
    model_press(s, c, l);
    bus.BTN_START = s;
    bus.BTN_CLEAR = c;
    bus.BTN_LAP   = l;
    advance(5);
    @(negedge clk);
    bus.BTN_START = 1'b0;
    bus.BTN_CLEAR = 1'b0;
    bus.BTN_LAP   = 1'b0;
    advance(5);
    #2;
  endtask

  task automatic glitch_start(input int len);
    @(negedge clk);
    bus.BTN_START = 1'b1;
    advance(len);
    @(negedge clk);
    bus.BTN_START = 1'b0;
    advance(10);
    #2;
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Only valid when the model is stopped: waits out the display lag, then expects a drained queue.
  task automatic settle(input string tag);
    advance(12);
    #2;
    chk_int(tag, exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.UPD === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL upd_unexpected: got BCD_OUT=%h expected no UPD", bus.BCD_OUT);
      end
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (bus.BCD_OUT === e) else begin
          failures++;
          $error("FAIL upd_value: got %h expected %h", bus.BCD_OUT, e);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.BTN_START = 1'b0;
    bus.BTN_CLEAR = 1'b0;
    bus.BTN_LAP   = 1'b0;
    model_reset();
    #2;
    chk16("rst_bcd",     bus.BCD_OUT,    16'h0000);
    chk1 ("rst_running", bus.RUNNING,    1'b0);
    chk1 ("rst_lap",     bus.LAP_ACTIVE, 1'b0);
    chk1 ("rst_upd",     bus.UPD,        1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: forty ticks
    press(1'b1, 1'b0, 1'b0);
    chk1("t1_running", bus.RUNNING, 1'b1);
    advance(150);
    press(1'b1, 1'b0, 1'b0);
    settle("t1_queue");
    chk16("t1_bcd_40", bus.BCD_OUT, 16'h0040);
    chk1 ("t1_paused", bus.RUNNING, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    settle("t1_clear_queue");

    // 2: glitch rejection, then a clean start/stop
    glitch_start(2);
    chk1("t2_glitch_idle", bus.RUNNING, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk1("t2_running", bus.RUNNING, 1'b1);
    advance(30);
    press(1'b1, 1'b0, 1'b0);
    chk1("t2_stopped", bus.RUNNING, 1'b0);
    settle("t2_queue");
    chk16("t2_bcd", bus.BCD_OUT, m_time);
    advance(20);
    #2;
    chk16("t2_bcd_hold", bus.BCD_OUT, m_time);
    chk1 ("t2_no_upd", bus.UPD, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    settle("t2_clear_queue");

    // 3: full run through 09.99, 59.99 and the wrap to 00.00
    press(1'b1, 1'b0, 1'b0);
    advance(6000 * TICK_DIV + 1 - 10);
    #2;
    chk1("t3_still_running", bus.RUNNING, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    settle("t3_queue");
    chk16("t3_wrap_bcd", bus.BCD_OUT, 16'h0000);
    press(1'b0, 1'b1, 1'b0);
    settle("t3_clear_queue");

    // 4: lap freeze at 12.34
    press(1'b1, 1'b0, 1'b0);
    advance(1234 * TICK_DIV + 2 - 10);
    press(1'b0, 1'b0, 1'b1);
    chk1 ("t4_lap_on", bus.LAP_ACTIVE, 1'b1);
    chk16("t4_frozen", bus.BCD_OUT, 16'h1234);
    advance(41);
    #2;
    chk16("t4_still_frozen", bus.BCD_OUT, 16'h1234);
    press(1'b0, 1'b0, 1'b1);
    chk1("t4_lap_off", bus.LAP_ACTIVE, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    settle("t4_queue");
    chk16("t4_cleared", bus.BCD_OUT, 16'h0000);
    chk1 ("t4_idle", bus.RUNNING, 1'b0);
    chk16("t4_state", {14'd0, bus.dbg_state}, 16'd0);

    // 5: START beats CLEAR in PAUSE; CLEAR ignored in RUN
    press(1'b1, 1'b0, 1'b0);
    advance(50);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk1("t5_start_wins", bus.RUNNING, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    chk1("t5_clear_in_run", bus.RUNNING, 1'b1);
    advance(20);
    press(1'b1, 1'b0, 1'b0);
    settle("t5_queue");
    chk16("t5_time_kept", bus.BCD_OUT, m_time);

    // 6: reset mid-count and mid-debounce
    press(1'b1, 1'b0, 1'b0);
    advance(37);
    @(negedge clk);
    bus.BTN_LAP = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk16("t6_bcd",     bus.BCD_OUT,    16'h0000);
    chk1 ("t6_running", bus.RUNNING,    1'b0);
    chk1 ("t6_lap",     bus.LAP_ACTIVE, 1'b0);
    chk1 ("t6_upd",     bus.UPD,        1'b0);
    bus.BTN_LAP = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    settle("t6_queue");
    advance(10);
    #2;
    chk1 ("t6_post_running", bus.RUNNING,    1'b0);
    chk1 ("t6_post_lap",     bus.LAP_ACTIVE, 1'b0);
    chk16("t6_post_bcd",     bus.BCD_OUT,    16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
